// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor.
// Each pipeline stage resolves GROUPS_PER_STAGE 4-bit CLA groups; the stage
// carry, the not-yet-used operand bits and the finished low sum bits travel
// down the pipe together with a per-stage valid bit. A valid/ready handshake
// stalls the whole pipe when the output is held by downstream.
// Optional build macro: CLA_ADDER_PIPE_SAT_EN -- saturate the result on
// signed overflow instead of wrapping.
module cla_adder_pipe #(
   parameter int WIDTH            = 16,
   parameter int GROUPS_PER_STAGE = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = WIDTH / (4 * GROUPS_PER_STAGE);
   localparam int NSKEW  = (STAGES > 1) ? STAGES - 1 : 1;

   // 4-bit lookahead group: returns {carry into bit 3, carry out, sum[3:0]}
   function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = x & y;
      p    = x ^ y;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
      return {c[3], c[4], p ^ c[3:0]};
   endfunction

   // stage registers
   logic             valid_q [STAGES];
   logic             carry_q [STAGES];
   logic [WIDTH-1:0] sum_q   [STAGES];
   logic [WIDTH-1:0] a_q     [NSKEW];
   logic [WIDTH-1:0] bx_q    [NSKEW];
   logic             ovf_q;

   logic             valid_d [STAGES];
   logic             carry_d [STAGES];
   logic [WIDTH-1:0] sum_d   [STAGES];
   logic [WIDTH-1:0] a_d     [NSKEW];
   logic [WIDTH-1:0] bx_d    [NSKEW];
   logic             ovf_d;

   // values feeding each stage's combinational logic
   logic             valid_i [STAGES];
   logic             carry_i [STAGES];
   logic [WIDTH-1:0] sum_i   [STAGES];
   logic [WIDTH-1:0] a_i     [STAGES];
   logic [WIDTH-1:0] bx_i    [STAGES];

   logic             c_s;
   logic             cm_s;
   logic [5:0]       r_s;
   logic [WIDTH-1:0] s_s;
   logic             en;

   assign en        = ~valid_q[STAGES-1] | out_ready;
   assign in_ready  = en;
   assign out_valid = valid_q[STAGES-1];
   assign sum       = sum_q[STAGES-1];
   assign cout      = carry_q[STAGES-1];
   assign ovf       = ovf_q;

   // Stage 0 takes the raw operands (b inverted, carry forced on subtract); later stages take the skew registers.
   always_comb begin
      valid_i[0] = in_valid;
      a_i[0]     = a;
      bx_i[0]    = sub ? ~b : b;
      carry_i[0] = sub ? 1'b1 : cin;
      sum_i[0]   = {WIDTH{1'b0}};
      for (int k = 1; k < STAGES; k++) begin
         valid_i[k] = valid_q[k-1];
         a_i[k]     = a_q[k-1];
         bx_i[k]    = bx_q[k-1];
         carry_i[k] = carry_q[k-1];
         sum_i[k]   = sum_q[k-1];
      end
   end

   // Resolve this stage's groups by rippling the group carries; the last stage also forms overflow and saturation.
   always_comb begin
      c_s   = 1'b0;
      cm_s  = 1'b0;
      r_s   = 6'd0;
      s_s   = {WIDTH{1'b0}};
      ovf_d = 1'b0;
      for (int k = 0; k < NSKEW; k++) begin
         a_d[k]  = {WIDTH{1'b0}};
         bx_d[k] = {WIDTH{1'b0}};
      end
      for (int k = 0; k < STAGES; k++) begin
         c_s = carry_i[k];
         s_s = sum_i[k];
         for (int j = 0; j < GROUPS_PER_STAGE; j++) begin
            r_s = cla4(a_i[k][(k*GROUPS_PER_STAGE+j)*4 +: 4],
                       bx_i[k][(k*GROUPS_PER_STAGE+j)*4 +: 4], c_s);
            s_s[(k*GROUPS_PER_STAGE+j)*4 +: 4] = r_s[3:0];
            c_s  = r_s[4];
            cm_s = r_s[5];
         end
         valid_d[k] = valid_i[k];
         carry_d[k] = c_s;
         sum_d[k]   = s_s;
         // last iteration wins: the top group holds the MSB
         ovf_d      = cm_s ^ c_s;
      end
      for (int k = 0; k < STAGES - 1; k++) begin
         a_d[k]  = a_i[k];
         bx_d[k] = bx_i[k];
      end
`ifdef CLA_ADDER_PIPE_SAT_EN
      sum_d[STAGES-1] = ovf_d ? (a_i[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                       : {1'b0, {(WIDTH-1){1'b1}}})
                              : sum_d[STAGES-1];
`endif
   end

   // Pipeline registers: reset wins, otherwise shift on enable and hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= 1'b0;
            carry_q[k] <= 1'b0;
            sum_q[k]   <= {WIDTH{1'b0}};
         end
         for (int k = 0; k < NSKEW; k++) begin
            a_q[k]  <= {WIDTH{1'b0}};
            bx_q[k] <= {WIDTH{1'b0}};
         end
         ovf_q <= 1'b0;
      end else if (en) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= valid_d[k];
            carry_q[k] <= carry_d[k];
            sum_q[k]   <= sum_d[k];
         end
         for (int k = 0; k < NSKEW; k++) begin
            a_q[k]  <= a_d[k];
            bx_q[k] <= bx_d[k];
         end
         ovf_q <= ovf_d;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= valid_q[k];
            carry_q[k] <= carry_q[k];
            sum_q[k]   <= sum_q[k];
         end
         for (int k = 0; k < NSKEW; k++) begin
            a_q[k]  <= a_q[k];
            bx_q[k] <= bx_q[k];
         end
         ovf_q <= ovf_q;
      end
   end

endmodule

// File: doc/cla_adder_pipe.md
CLA_ADDER_PIPE -- requirements
Module: cla_adder_pipe

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits; SHALL be a multiple of 4*GROUPS_PER_STAGE.
REQ-002 Parameter: GROUPS_PER_STAGE, 2, number of 4-bit CLA groups resolved per pipeline stage.
REQ-003 Derived constant: STAGES = WIDTH/(4*GROUPS_PER_STAGE), which is the pipeline depth and latency in cycles.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  operand beat present.
REQ-007 in_ready  out  1  block accepts a beat this cycle.
REQ-008 a, b  in  WIDTH  operands.
REQ-009 cin  in  1  carry-in; ignored when sub=1.
REQ-010 sub  in  1  0 = a+b+cin, 1 = a-b.
REQ-011 out_valid  out  1  result beat present.
REQ-012 out_ready  in  1  downstream accepts the result.
REQ-013 sum  out  WIDTH  result.
REQ-014 cout  out  1  carry-out of the MSB; on subtract, 1 = no borrow.
REQ-015 ovf  out  1  two's-complement signed overflow.

Function
REQ-016 Each 4-bit group SHALL use generate g=a&b' and propagate p=a^b', with carry-lookahead carries computed inside the group. Here b' = b (add) or ~b (sub).
REQ-017 Subtract SHALL use b'=~b with carry-in forced to 1.
REQ-018 Stage k SHALL resolve groups k*GROUPS_PER_STAGE through (k+1)*GROUPS_PER_STAGE-1, using the registered carry from stage k-1 (stage 0 uses the effective cin).
REQ-019 Unprocessed upper operand bits and finished lower sum bits SHALL be carried forward in skew registers alongside the stage carry and a per-stage valid bit.
REQ-020 Latency SHALL be exactly STAGES cycles from an accepted beat (in_valid&in_ready) to out_valid, with no stalls in between.
REQ-021 Advance enable SHALL be en = ~out_valid | out_ready; the pipeline and every valid bit shift only when en=1; in_ready = en.
REQ-022 While en=0, all stage registers and the outputs sum/cout/ovf/out_valid SHALL hold unchanged.
REQ-023 Accepting an input and emitting an output in the same cycle SHALL be supported, giving full throughput of one beat per cycle.
REQ-024 Bubbles (in_valid=0 while en=1) SHALL propagate as invalid stages; bubbles are not collapsed.
REQ-025 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-026 Results SHALL emerge in acceptance order; no beat may be dropped or duplicated.

Reset
REQ-027 While rst=1 at a clock edge, all stage valid bits and out_valid SHALL clear to 0, and sum, cout and ovf SHALL clear to 0.
REQ-028 Reset SHALL take priority over the advance enable.
REQ-029 In-flight beats SHALL be discarded on reset and never emitted.
REQ-030 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-031 Macro CLA_ADDER_PIPE_SAT_EN controls signed saturation.
- When defined: if ovf=1, sum SHALL be 0x7F..F when the operands are non-negative (a MSB = 0), and 0x80..0 otherwise. ovf and cout are still reported as computed.
- When undefined: sum SHALL wrap modulo 2^WIDTH.
- The port list SHALL be identical in both builds.

Verification (WIDTH=16, GROUPS_PER_STAGE=2, latency 2; out_ready=1 unless stated)
REQ-032 a=0x00FF, b=0x0001, cin=0, sub=0 -> 2 cycles later sum=0x0100, cout=0, ovf=0.
REQ-033 a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0.
REQ-034 a=0x7FFF, b=0x0001, add -> without macro sum=0x8000, ovf=1; with macro sum=0x7FFF, ovf=1.
REQ-035 sub: a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001 -> sum=0x7FFF (without macro) or 0x8000 (with macro), ovf=1.
REQ-036 Four back-to-back beats with out_ready low for 3 cycles -> in_ready low exactly while out_valid=1 and out_ready=0, outputs stable while stalled, all four results emitted in order.
REQ-037 rst pulsed for 1 cycle with 2 beats in flight -> out_valid=0 on the next cycle, neither beat ever emitted, in_ready=1 after reset.
